// File: rtl/regs_sb.sv
// Multi-port integer register file with a per-register busy/tag scoreboard,
// tag-checked writeback and same-cycle write-to-read bypass.
module regs_sb #(
  parameter int LEN_REG      = 32,
  parameter int NUM_REG      = 32,
  parameter int LEN_REG_ADDR = $clog2(NUM_REG),
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 2,
  parameter int LEN_TAG      = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           issue_en,
  input  logic [LEN_REG_ADDR-1:0]        issue_addr,
  output logic [LEN_TAG-1:0]             issue_tag,
  input  logic [NUM_RD*LEN_REG_ADDR-1:0] rd_addr,
  output logic [NUM_RD*LEN_REG-1:0]      rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*LEN_REG_ADDR-1:0] wr_addr,
  input  logic [NUM_WR*LEN_TAG-1:0]      wr_tag,
  input  logic [NUM_WR*LEN_REG-1:0]      wr_data
);

  localparam int AW = LEN_REG_ADDR;
  localparam int TW = LEN_TAG;
  localparam int DW = LEN_REG;

  logic [DW-1:0]      data_q [NUM_REG];
  logic [DW-1:0]      data_d [NUM_REG];
  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;
  logic [TW-1:0]      tag_q  [NUM_REG];
  logic [TW-1:0]      tag_d  [NUM_REG];
  logic [TW-1:0]      cnt_q;
  logic [TW-1:0]      cnt_d;

  logic [AW-1:0]      wa [NUM_WR];
  logic [TW-1:0]      wt [NUM_WR];
  logic [DW-1:0]      wd [NUM_WR];
  logic [NUM_WR-1:0]  wr_acc;
  logic [NUM_REG-1:0] wr_hit;
  logic [DW-1:0]      wr_win [NUM_REG];
  logic [AW-1:0]      ra [NUM_RD];
  logic               issue_fire;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_REG);
  endfunction

  // One acceptance decision per write port, shared by the register update and
  // the read bypass so a bypassed value always matches what gets stored.
  always_comb begin
    wr_acc = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = wr_addr[j*AW +: AW];
      wt[j] = wr_tag[j*TW +: TW];
      wd[j] = wr_data[j*DW +: DW];
      wr_acc[j] = wr_en[j] && addr_ok(wa[j]) &&
                  (!busy_q[wa[j]] || (tag_q[wa[j]] == wt[j]));
    end
    for (int r = 0; r < NUM_REG; r++) begin
      wr_hit[r] = 1'b0;
      wr_win[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_acc[j] && (wa[j] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_win[r] = wd[j];
        end
      end
    end
  end

  // Issue overrides the busy/tag effect of a same-cycle write, never the data.
  always_comb begin
    issue_fire = issue_en && addr_ok(issue_addr);
    cnt_d      = issue_fire ? cnt_q + TW'(1) : cnt_q;
    busy_d     = '0;
    data_d[0]  = '0;
    tag_d[0]   = '0;
    for (int r = 1; r < NUM_REG; r++) begin
      data_d[r] = wr_hit[r] ? wr_win[r] : data_q[r];
      busy_d[r] = wr_hit[r] ? 1'b0 : busy_q[r];
      tag_d[r]  = tag_q[r];
      if (issue_fire && (issue_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      busy_q <= '0;
      for (int r = 0; r < NUM_REG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      for (int r = 0; r < NUM_REG; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

  // Reads are forced to zero while reset is held so bypassed writes stay hidden.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k] = rd_addr[k*AW +: AW];
      if (rstn && addr_ok(ra[k])) begin
        if (wr_hit[ra[k]]) begin
          rd_data[k*DW +: DW] = wr_win[ra[k]];
        end else begin
          rd_data[k*DW +: DW] = data_q[ra[k]];
          rd_busy[k]          = busy_q[ra[k]];
        end
      end
    end
  end

  assign issue_tag = cnt_q;

endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: stimulus pushes expected read/tag values into a
// scoreboard queue, a negedge monitor pops and compares them per cycle.
module tb_regs_sb;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int TW  = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic               issue_en;
  logic [AW-1:0]      issue_addr;
  logic [TW-1:0]      issue_tag;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_busy;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*TW-1:0]  wr_tag;
  logic [NWR*DW-1:0]  wr_data;

  regs_sb #(
    .LEN_REG(DW), .NUM_REG(NR), .LEN_REG_ADDR(AW),
    .NUM_RD(NRD), .NUM_WR(NWR), .LEN_TAG(TW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_tag(issue_tag),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_tag(wr_tag), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    int            kind;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en   = 1'b0;
    issue_addr = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_tag     = '0;
    wr_data    = '0;
  endtask

  task automatic setRead(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic setWrite(input int j, input int a, input int t, input logic [DW-1:0] d);
    wr_en[j]            = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_tag[j*TW +: TW]  = TW'(t);
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic setIssue(input int a);
    issue_en   = 1'b1;
    issue_addr = AW'(a);
  endtask

  task automatic expectRead(input int k, input logic [DW-1:0] d, input logic b, input string n);
    exp_t e;
    e.cyc = cyc; e.kind = 0; e.port = k; e.data = d; e.busy = b; e.name = n;
    sb.push_back(e);
  endtask

  task automatic expectTag(input int t, input string n);
    exp_t e;
    e.cyc = cyc; e.kind = 1; e.port = 0; e.data = DW'(t); e.busy = 1'b0; e.name = n;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [DW-1:0] gd;
    logic          gb;
    checks++;
    if (e.cyc != cyc) begin
      errors++;
      $display("[TB] FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end else if (e.kind == 0) begin
      gd = rd_data[e.port*DW +: DW];
      gb = rd_busy[e.port];
      if (gd !== e.data || gb !== e.busy) begin
        errors++;
        $display("[TB] FAIL %s: port %0d got data=%h busy=%b, required data=%h busy=%b",
                 e.name, e.port, gd, gb, e.data, e.busy);
      end
    end else begin
      if (issue_tag !== e.data[TW-1:0]) begin
        errors++;
        $display("[TB] FAIL %s: issue_tag got %0d, required %0d", e.name, issue_tag, e.data[TW-1:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) checkOutput(sb.pop_front());
  end

  task automatic applyStimulus();
    rstn    = 1'b0;
    rd_addr = '0;
    idle();
    step();
    // Activity while held in reset must neither show on reads nor be stored.
    setWrite(0, 1, 0, 32'hFFFF_FFFF);
    setIssue(2);
    setRead(0, 1); setRead(1, 2);
    expectRead(0, 32'h0, 1'b0, "rst_rd0");
    expectRead(1, 32'h0, 1'b0, "rst_rd1");
    expectTag(0, "rst_tag");
    step();
    rstn = 1'b1;
    idle();
    for (int a = 1; a < NR; a++) begin
      setRead(0, a); setRead(1, NR - a);
      expectRead(0, 32'h0, 1'b0, $sformatf("init_p0_r%0d", a));
      expectRead(1, 32'h0, 1'b0, $sformatf("init_p1_r%0d", NR - a));
      if (a == 1) expectTag(0, "init_tag");
      step();
    end

    setIssue(5); setRead(0, 5);
    expectTag(0, "r5_issue_tag");
    expectRead(0, 32'h0, 1'b0, "r5_pre_issue");
    step();
    idle();
    expectRead(0, 32'h0, 1'b1, "r5_busy");
    expectTag(1, "r5_cnt_after");
    step();
    setWrite(0, 5, 0, 32'hDEAD_BEEF);
    expectRead(0, 32'hDEAD_BEEF, 1'b0, "r5_bypass");
    step();
    idle();
    expectRead(0, 32'hDEAD_BEEF, 1'b0, "r5_stored");
    step();

    setIssue(7); setRead(0, 7);
    expectTag(1, "r7_issue1");
    step();
    setIssue(7);
    expectTag(2, "r7_issue2");
    step();
    idle();
    setWrite(1, 7, 1, 32'h11);
    expectRead(0, 32'h0, 1'b1, "r7_stale_rejected");
    step();
    idle();
    expectRead(0, 32'h0, 1'b1, "r7_still_busy");
    step();
    setWrite(0, 7, 2, 32'h22);
    expectRead(0, 32'h22, 1'b0, "r7_bypass");
    step();
    idle();
    expectRead(0, 32'h22, 1'b0, "r7_stored");
    expectTag(3, "r7_cnt");
    step();

    setWrite(0, 3, 0, 32'hAA); setWrite(1, 3, 0, 32'hBB);
    setRead(0, 3); setRead(1, 3);
    expectRead(0, 32'hBB, 1'b0, "r3_dual_p0");
    expectRead(1, 32'hBB, 1'b0, "r3_dual_p1");
    step();
    idle();
    expectRead(0, 32'hBB, 1'b0, "r3_stored");
    step();

    setIssue(9); setWrite(0, 9, 0, 32'h55); setRead(0, 9);
    expectTag(3, "r9_issue_tag");
    expectRead(0, 32'h55, 1'b0, "r9_bypass_with_issue");
    step();
    idle();
    expectRead(0, 32'h55, 1'b1, "r9_busy_after");
    expectTag(4, "r9_cnt");
    step();
    setWrite(1, 9, 2, 32'h66);
    expectRead(0, 32'h55, 1'b0 | 1'b1, "r9_old_tag_rejected");
    step();
    idle();
    setWrite(1, 9, 3, 32'h77);
    expectRead(0, 32'h77, 1'b0, "r9_new_tag_accepted");
    step();
    idle();
    expectRead(0, 32'h77, 1'b0, "r9_stored");
    step();

    setIssue(0); setWrite(0, 0, 0, 32'h99); setWrite(1, 0, 0, 32'h98);
    setRead(0, 0); setRead(1, 0);
    expectRead(0, 32'h0, 1'b0, "r0_p0");
    expectRead(1, 32'h0, 1'b0, "r0_p1");
    expectTag(4, "r0_tag_before");
    step();
    idle();
    expectRead(0, 32'h0, 1'b0, "r0_after");
    expectTag(4, "r0_cnt_unchanged");
    step();

    // Nine issues from cnt=4 walk the 3-bit counter through a full wrap.
    for (int i = 0; i < 9; i++) begin
      setIssue(10);
      expectTag((4 + i) % 8, $sformatf("wrap_%0d", i));
      step();
    end
    idle();
    expectTag(5, "wrap_final");
    step();

    setWrite(0, 4, 0, 32'h44); setRead(0, 4); setRead(1, 4);
    step();
    idle();
    setIssue(4);
    expectRead(0, 32'h44, 1'b0, "r4_pre_issue");
    expectTag(5, "r4_issue_tag");
    step();
    idle();
    expectRead(0, 32'h44, 1'b1, "r4_busy");
    expectRead(1, 32'h44, 1'b1, "r4_busy_p1");
    step();
    #1;
    rstn = 1'b0;
    expectRead(0, 32'h0, 1'b0, "async_rd0");
    expectRead(1, 32'h0, 1'b0, "async_rd1");
    expectTag(0, "async_tag");
    #5;
    rstn = 1'b1;
    step();
    expectRead(0, 32'h0, 1'b0, "post_rst_r4");
    expectTag(0, "post_rst_tag");
    step();
    setWrite(1, 4, 6, 32'h1234);
    expectRead(0, 32'h1234, 1'b0, "post_rst_wr_bypass");
    step();
    idle();
    expectRead(0, 32'h1234, 1'b0, "post_rst_wr_stored");
    step();
    step();
    step();
  endtask

  initial begin
    applyStimulus();
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: time limit reached, required run to complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
